// File: rtl/vending_machine_mc.sv
`default_nettype none
// ============================================================================
//  Module   : vending_machine_mc
//  Brief    : Multi-product vending controller with accumulated credit,
//             cancel/refund, runtime price/stock config and chunked change.
//             Optional macro VEND_TIMEOUT_EN adds an idle-credit auto refund.
//  Revision : 1.0 - initial release
// ============================================================================
module vending_machine_mc #(
    parameter int NUM_PRODUCTS   = 6,
    parameter int COIN_W         = 4,
    parameter int CREDIT_W       = 8,
    parameter int STOCK_W        = 4,
    parameter int INIT_STOCK     = 4,
    parameter int CHANGE_MAX     = 10,
    parameter int TIMEOUT_CYCLES = 1000,
    localparam int PW            = (NUM_PRODUCTS > 2) ? $clog2(NUM_PRODUCTS) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                coin_valid,
    input  logic [COIN_W-1:0]   coin_value,
    input  logic                sel_valid,
    input  logic [PW-1:0]       sel_code,
    input  logic                cancel,
    input  logic                cfg_we,
    input  logic                cfg_is_price,
    input  logic [PW-1:0]       cfg_idx,
    input  logic [CREDIT_W-1:0] cfg_data,
    output logic                dispense,
    output logic [PW-1:0]       dispense_code,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amount,
    output logic [CREDIT_W-1:0] credit,
    output logic                out_of_stock,
    output logic                insufficient,
    output logic                coin_reject,
    output logic                busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CREDIT = 2'd1,
        S_VEND   = 2'd2,
        S_CHANGE = 2'd3
    } state_t;

    localparam logic [CREDIT_W-1:0] c_chg_max = CREDIT_W'(CHANGE_MAX);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W-1:0] w_credit_nxt;
    logic [PW-1:0]       r_vend_idx;
    logic [PW-1:0]       w_vend_idx_nxt;
    logic [CREDIT_W-1:0] r_vend_price;
    logic [CREDIT_W-1:0] w_vend_price_nxt;
    logic                r_dispense;
    logic                w_dispense_nxt;
    logic                r_oos;
    logic                w_oos_nxt;
    logic                r_insuf;
    logic                w_insuf_nxt;
    logic                r_coin_rej;
    logic                w_coin_rej_nxt;
    logic                w_stock_dec;

    logic [STOCK_W-1:0]  r_stock [NUM_PRODUCTS];
    logic [CREDIT_W-1:0] r_price [NUM_PRODUCTS];

    logic                w_sel_ok;
    logic [PW-1:0]       w_sel_idx;
    logic [CREDIT_W-1:0] w_sel_price;
    logic                w_sel_avail;
    logic                w_sel_go;
    logic                w_cfg_wr;
    logic [CREDIT_W:0]   w_coin_sum;
    logic [CREDIT_W-1:0] w_chg_amt;
    logic                w_timeout;

    // Out-of-range selections are redirected to slot 0 so the arrays are never
    // indexed past their end; w_sel_ok masks the result.
    assign w_sel_ok    = (32'(sel_code) < NUM_PRODUCTS);
    assign w_sel_idx   = w_sel_ok ? sel_code : '0;
    assign w_sel_price = r_price[w_sel_idx];
    assign w_sel_avail = w_sel_ok && (r_stock[w_sel_idx] != '0);
    assign w_sel_go    = sel_valid && w_sel_avail && (r_credit >= w_sel_price);
    assign w_cfg_wr    = cfg_we && (r_state == S_IDLE) && (32'(cfg_idx) < NUM_PRODUCTS);
    assign w_coin_sum  = {1'b0, r_credit} + (CREDIT_W+1)'(coin_value);
    assign w_chg_amt   = (r_credit < c_chg_max) ? r_credit : c_chg_max;

`ifdef VEND_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_to_cnt;
    logic          w_to_idle;

    assign w_to_idle = (r_state == S_CREDIT) && !coin_valid && !sel_valid;
    assign w_timeout = w_to_idle && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_to_cnt <= '0;
        end else if (!w_to_idle || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_credit_nxt     = r_credit;
        w_vend_idx_nxt   = r_vend_idx;
        w_vend_price_nxt = r_vend_price;
        w_dispense_nxt   = 1'b0;
        w_oos_nxt        = 1'b0;
        w_insuf_nxt      = 1'b0;
        w_coin_rej_nxt   = 1'b0;
        w_stock_dec      = 1'b0;
        case (r_state)
            S_IDLE, S_CREDIT: begin
                if ((cancel || w_timeout) && (r_credit != '0)) begin
                    w_state_nxt    = S_CHANGE;
                    w_coin_rej_nxt = coin_valid;
                end else if (w_sel_go) begin
                    // Price is captured now so a same-cycle config write
                    // cannot change what this vend costs.
                    w_state_nxt      = S_VEND;
                    w_dispense_nxt   = 1'b1;
                    w_vend_idx_nxt   = sel_code;
                    w_vend_price_nxt = w_sel_price;
                    w_coin_rej_nxt   = coin_valid;
                end else begin
                    if (sel_valid) begin
                        w_oos_nxt   = !w_sel_avail;
                        w_insuf_nxt = w_sel_avail;
                    end
                    if (coin_valid) begin
                        if (w_coin_sum[CREDIT_W]) begin
                            w_coin_rej_nxt = 1'b1;
                        end else begin
                            w_credit_nxt = w_coin_sum[CREDIT_W-1:0];
                            w_state_nxt  = (w_coin_sum == '0) ? S_IDLE : S_CREDIT;
                        end
                    end
                end
            end
            S_VEND: begin
                w_credit_nxt   = r_credit - r_vend_price;
                w_stock_dec    = 1'b1;
                w_state_nxt    = (r_credit != r_vend_price) ? S_CHANGE : S_IDLE;
                w_coin_rej_nxt = coin_valid;
            end
            S_CHANGE: begin
                w_credit_nxt   = r_credit - w_chg_amt;
                w_state_nxt    = (r_credit == w_chg_amt) ? S_IDLE : S_CHANGE;
                w_coin_rej_nxt = coin_valid;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_credit     <= '0;
            r_vend_idx   <= '0;
            r_vend_price <= '0;
            r_dispense   <= 1'b0;
            r_oos        <= 1'b0;
            r_insuf      <= 1'b0;
            r_coin_rej   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_credit     <= w_credit_nxt;
            r_vend_idx   <= w_vend_idx_nxt;
            r_vend_price <= w_vend_price_nxt;
            r_dispense   <= w_dispense_nxt;
            r_oos        <= w_oos_nxt;
            r_insuf      <= w_insuf_nxt;
            r_coin_rej   <= w_coin_rej_nxt;
        end
    end

    // Config writes only happen in IDLE and decrements only in VEND, so the
    // two update paths never collide on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_PRODUCTS; i++) begin
                r_stock[i] <= STOCK_W'(INIT_STOCK);
                r_price[i] <= CREDIT_W'(5 * ((i % 3) + 1));
            end
        end else begin
            for (int i = 0; i < NUM_PRODUCTS; i++) begin
                if (w_cfg_wr && (cfg_idx == PW'(i))) begin
                    if (cfg_is_price) begin
                        r_price[i] <= cfg_data;
                    end else begin
                        r_stock[i] <= cfg_data[STOCK_W-1:0];
                    end
                end else if (w_stock_dec && (r_vend_idx == PW'(i)) && (r_stock[i] != '0)) begin
                    r_stock[i] <= r_stock[i] - 1'b1;
                end
            end
        end
    end

    assign dispense      = r_dispense;
    assign dispense_code = r_dispense ? r_vend_idx : '0;
    assign change_valid  = (r_state == S_CHANGE);
    assign change_amount = (r_state == S_CHANGE) ? w_chg_amt : '0;
    assign credit        = r_credit;
    assign out_of_stock  = r_oos;
    assign insufficient  = r_insuf;
    assign coin_reject   = r_coin_rej;
    assign busy          = (r_state == S_VEND) || (r_state == S_CHANGE);

endmodule
`default_nettype wire
